// File: rtl/data_memory_controller.sv
// Load/store controller between the core LSU and a synchronous byte-enabled RAM.
// Word-crossing accesses run as two RAM beats; RAM read latency is a parameter.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// LO      | first (or only) RAM beat strobed
// WAIT_LO | waiting for low-word read data, sampled on the last wait cycle
// HI      | second RAM beat of a word-crossing access
// WAIT_HI | waiting for high-word read data
// RESP    | one-cycle response pulse
module data_memory_controller #(
  parameter logic [31:0] DATA_BEGIN       = 32'h1001_0000,
  parameter logic [31:0] DATA_END         = 32'h1001_FFFF,
  parameter int          MEM_WORD_ADDR_W  = 15,
  parameter int          READ_LATENCY     = 1,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [2:0]                 req_format,
  input  logic [31:0]                req_address,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_error,
  output logic                       mem_en,
  output logic                       mem_wren,
  output logic [MEM_WORD_ADDR_W-1:0] mem_address,
  output logic [3:0]                 mem_byteena,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO      = 3'd1,
    WAIT_LO = 3'd2,
    HI      = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  state_t                     state;
  logic [MEM_WORD_ADDR_W-1:0] lo_addr;
  logic [7:0]                 be_q;
  logic [63:0]                wd_q;
  logic [1:0]                 off_q;
  logic [2:0]                 fmt_q;
  logic                       write_q;
  logic                       cross_q;
  logic [31:0]                lo_data;
  logic [1:0]                 wait_cnt;

  logic [2:0]  acc_size;
  logic [3:0]  acc_mask;
  logic [1:0]  acc_off;
  logic        acc_cross;
  logic [32:0] acc_last;
  logic        acc_fmt_err;
  logic        acc_range_err;
  logic        acc_err;
  logic [7:0]  acc_be;
  logic [63:0] acc_wd;

  always_comb begin
    acc_size = 3'd4;
    acc_mask = 4'b1111;
    case (req_format[1:0])
      2'b00: begin acc_size = 3'd1; acc_mask = 4'b0001; end
      2'b01: begin acc_size = 3'd2; acc_mask = 4'b0011; end
      default: begin acc_size = 3'd4; acc_mask = 4'b1111; end
    endcase
    acc_off       = req_address[1:0];
    acc_cross     = (({1'b0, acc_off}) + acc_size) > 3'd4;
    // 33-bit sum so an access straddling 2^32 cannot wrap back into range
    acc_last      = {1'b0, req_address} + {30'b0, acc_size} - 33'd1;
    acc_fmt_err   = (req_format[1:0] == 2'b11) || (req_format[2:1] == 2'b11) ||
                    (req_write && req_format[2]);
    acc_range_err = (req_address < DATA_BEGIN) || (acc_last > {1'b0, DATA_END});
    acc_err       = acc_fmt_err || acc_range_err || (acc_cross && !ALLOW_MISALIGNED);
    acc_be        = {4'b0, acc_mask} << acc_off;
    acc_wd        = {32'b0, req_wdata} << {acc_off, 3'b000};
  end

  function automatic logic [31:0] extend(input logic [63:0] both, input logic [1:0] off,
                                         input logic [2:0] fmt);
    logic [63:0] sh;
    sh = both >> {off, 3'b000};
    case (fmt)
      3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extend = {24'b0, sh[7:0]};
      3'b101:  extend = {16'b0, sh[15:0]};
      default: extend = sh[31:0];
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      mem_en      <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_byteena <= '0;
      mem_wdata   <= '0;
      lo_addr     <= '0;
      be_q        <= '0;
      wd_q        <= '0;
      off_q       <= '0;
      fmt_q       <= '0;
      write_q     <= 1'b0;
      cross_q     <= 1'b0;
      lo_data     <= '0;
      wait_cnt    <= '0;
    end else begin
      mem_en      <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_byteena <= '0;
      mem_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lo_addr   <= req_address[MEM_WORD_ADDR_W+1:2];
            be_q      <= acc_be;
            wd_q      <= acc_wd;
            off_q     <= acc_off;
            fmt_q     <= req_format;
            write_q   <= req_write;
            cross_q   <= acc_cross;
            if (acc_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              state       <= LO;
              mem_en      <= 1'b1;
              mem_wren    <= req_write;
              mem_address <= req_address[MEM_WORD_ADDR_W+1:2];
              mem_byteena <= acc_be[3:0];
              mem_wdata   <= acc_wd[31:0];
            end
          end
        end
        LO: begin
          if (!write_q) begin
            state    <= WAIT_LO;
            wait_cnt <= WAIT_INIT;
          end else if (cross_q) begin
            state       <= HI;
            mem_en      <= 1'b1;
            mem_wren    <= 1'b1;
            mem_address <= lo_addr + MEM_WORD_ADDR_W'(1);
            mem_byteena <= be_q[7:4];
            mem_wdata   <= wd_q[63:32];
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (wait_cnt == 2'd0) begin
            lo_data <= mem_rdata;
            if (cross_q) begin
              state       <= HI;
              mem_en      <= 1'b1;
              mem_address <= lo_addr + MEM_WORD_ADDR_W'(1);
              mem_byteena <= be_q[7:4];
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= extend({32'b0, mem_rdata}, off_q, fmt_q);
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        HI: begin
          if (write_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state    <= WAIT_HI;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT_HI: begin
          if (wait_cnt == 2'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= extend({mem_rdata, lo_data}, off_q, fmt_q);
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench: three controller instances (L=1 misaligned on, L=1 misaligned off,
// L=3 misaligned on), each with its own behavioural RAM.
module tb_data_memory_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [2:0]  rv;
  logic        req_write;
  logic [2:0]  req_format;
  logic [31:0] req_address;
  logic [31:0] req_wdata;

  logic        rdy [3];
  logic        rsv [3];
  logic        rse [3];
  logic        men [3];
  logic        mwe [3];
  logic [31:0] rsd [3];
  logic [14:0] madr [3];
  logic [3:0]  mbe [3];
  logic [31:0] mwd [3];
  logic [31:0] mrd [3];

  logic [31:0] ram  [3][16];
  logic [31:0] pipe [3][3];

  int checks = 0;
  int errors = 0;

  int          last_rc, last_ens, last_first, last_wait, busy_rdy;
  logic        last_resp_after;
  logic [31:0] last_rd;
  logic        last_re;
  logic [14:0] b_adr [2];
  logic [3:0]  b_be  [2];
  logic [31:0] b_wd  [2];
  logic        b_we  [2];

  data_memory_controller #(.READ_LATENCY(1), .ALLOW_MISALIGNED(1'b1)) u0 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_write(req_write), .req_format(req_format), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(rsv[0]), .resp_rdata(rsd[0]), .resp_error(rse[0]),
    .mem_en(men[0]), .mem_wren(mwe[0]), .mem_address(madr[0]), .mem_byteena(mbe[0]),
    .mem_wdata(mwd[0]), .mem_rdata(mrd[0]));

  data_memory_controller #(.READ_LATENCY(1), .ALLOW_MISALIGNED(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_write(req_write), .req_format(req_format), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(rsv[1]), .resp_rdata(rsd[1]), .resp_error(rse[1]),
    .mem_en(men[1]), .mem_wren(mwe[1]), .mem_address(madr[1]), .mem_byteena(mbe[1]),
    .mem_wdata(mwd[1]), .mem_rdata(mrd[1]));

  data_memory_controller #(.READ_LATENCY(3), .ALLOW_MISALIGNED(1'b1)) u2 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_format(req_format), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(rsv[2]), .resp_rdata(rsd[2]), .resp_error(rse[2]),
    .mem_en(men[2]), .mem_wren(mwe[2]), .mem_address(madr[2]), .mem_byteena(mbe[2]),
    .mem_wdata(mwd[2]), .mem_rdata(mrd[2]));

  // RAM contents reload while reset is held; index is the low 4 bits of the word address
  always @(posedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (!reset_n) begin
        for (int i = 0; i < 16; i++) ram[d][i] <= 32'h0;
        ram[d][0]  <= 32'h8122_3344;
        ram[d][1]  <= 32'h8899_AABB;
        ram[d][15] <= 32'hCAFE_F00D;
      end else if (men[d] && mwe[d]) begin
        for (int b = 0; b < 4; b++)
          if (mbe[d][b]) ram[d][madr[d][3:0]][8*b +: 8] <= mwd[d][8*b +: 8];
      end
      if (men[d] && !mwe[d]) pipe[d][0] <= ram[d][madr[d][3:0]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end

  always_comb begin
    mrd[0] = pipe[0][0];
    mrd[1] = pipe[1][0];
    mrd[2] = pipe[2][2];
  end

  task automatic do_req(input int d, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clock);
    last_resp_after = rsv[d];
    last_wait = 1;
    while (!rdy[d] && last_wait < 50) begin
      @(negedge clock);
      last_wait++;
    end
    req_write = w; req_format = f; req_address = a; req_wdata = wd;
    rv[d] = 1'b1;
    @(posedge clock);
    #1 rv[d] = 1'b0;
    last_rc = -1; last_ens = 0; last_first = -1; busy_rdy = 0;
    last_rd = 32'h0; last_re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_adr[i] = '0; b_be[i] = '0; b_wd[i] = '0; b_we[i] = 1'b0;
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (men[d]) begin
        if (last_ens < 2) begin
          b_adr[last_ens] = madr[d]; b_be[last_ens] = mbe[d];
          b_wd[last_ens] = mwd[d]; b_we[last_ens] = mwe[d];
        end
        if (last_first < 0) last_first = n;
        last_ens++;
      end
      if (rdy[d]) busy_rdy++;
      if (rsv[d]) begin
        last_rc = n; last_rd = rsd[d]; last_re = rse[d];
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 1", d, rdy[d]); end
      checks++;
      if ({rsv[d], rse[d], men[d], mwe[d], mbe[d], madr[d], rsd[d], mwd[d]} !== 87'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", d,
                 {rsv[d], rse[d], men[d], mwe[d], mbe[d], madr[d], rsd[d], mwd[d]});
      end
    end
  endtask

  task automatic test_lw;
    do_req(0, 1'b0, 3'b010, 32'h1001_0004, 32'h0);
    checks++; if (last_first !== 1) begin errors++; $display("FAIL lw_mem_en_cycle: got %0d expected 1", last_first); end
    checks++; if (last_rc !== 3) begin errors++; $display("FAIL lw_resp_cycle: got %0d expected 3", last_rc); end
    checks++; if (last_rd !== 32'h8899_AABB) begin errors++; $display("FAIL lw_rdata: got %h expected 8899aabb", last_rd); end
    checks++; if (last_re !== 1'b0) begin errors++; $display("FAIL lw_error: got %b expected 0", last_re); end
    checks++; if (b_adr[0] !== 15'h4001 || b_be[0] !== 4'hF || b_we[0] !== 1'b0) begin
      errors++; $display("FAIL lw_beat: got adr %h be %b we %b expected 4001 1111 0", b_adr[0], b_be[0], b_we[0]);
    end
    checks++; if (busy_rdy !== 0) begin errors++; $display("FAIL lw_ready_busy: got %0d expected 0", busy_rdy); end
  endtask

  task automatic test_byte_half_loads;
    logic [2:0]  fmt [4];
    logic [31:0] adr [4];
    logic [31:0] exp [4];
    fmt[0] = 3'b000; adr[0] = 32'h1001_0003; exp[0] = 32'hFFFF_FF81;
    fmt[1] = 3'b100; adr[1] = 32'h1001_0003; exp[1] = 32'h0000_0081;
    fmt[2] = 3'b001; adr[2] = 32'h1001_0002; exp[2] = 32'hFFFF_8122;
    fmt[3] = 3'b101; adr[3] = 32'h1001_0000; exp[3] = 32'h0000_3344;
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, fmt[i], adr[i], 32'h0);
      checks++; if (last_rd !== exp[i]) begin errors++; $display("FAIL load_ext[%0d]: got %h expected %h", i, last_rd, exp[i]); end
      checks++; if (last_rc !== 3) begin errors++; $display("FAIL load_ext_cycle[%0d]: got %0d expected 3", i, last_rc); end
    end
  endtask

  task automatic test_back_to_back;
    do_req(0, 1'b0, 3'b010, 32'h1001_0004, 32'h0);
    do_req(0, 1'b0, 3'b010, 32'h1001_0000, 32'h0);
    checks++; if (last_resp_after !== 1'b0) begin errors++; $display("FAIL b2b_resp_one_cycle: got %b expected 0", last_resp_after); end
    checks++; if (last_wait !== 1) begin errors++; $display("FAIL b2b_accept_gap: got %0d expected 1", last_wait); end
    checks++; if (last_rc !== 3 || last_rd !== 32'h8122_3344) begin
      errors++; $display("FAIL b2b_second: got cycle %0d data %h expected 3 81223344", last_rc, last_rd);
    end
  endtask

  task automatic test_stores;
    do_req(0, 1'b1, 3'b001, 32'h1001_0003, 32'h0000_BEEF);
    checks++; if (last_ens !== 2) begin errors++; $display("FAIL sh_split_beats: got %0d expected 2", last_ens); end
    checks++; if (b_adr[0] !== 15'h4000 || b_be[0] !== 4'b1000 || b_wd[0] !== 32'hEF00_0000 || b_we[0] !== 1'b1) begin
      errors++; $display("FAIL sh_beat1: got %h %b %h %b expected 4000 1000 ef000000 1", b_adr[0], b_be[0], b_wd[0], b_we[0]);
    end
    checks++; if (b_adr[1] !== 15'h4001 || b_be[1] !== 4'b0001 || b_wd[1] !== 32'h0000_00BE || b_we[1] !== 1'b1) begin
      errors++; $display("FAIL sh_beat2: got %h %b %h %b expected 4001 0001 000000be 1", b_adr[1], b_be[1], b_wd[1], b_we[1]);
    end
    checks++; if (last_rc !== 3 || last_rd !== 32'h0 || last_re !== 1'b0) begin
      errors++; $display("FAIL sh_resp: got cycle %0d data %h err %b expected 3 0 0", last_rc, last_rd, last_re);
    end
    do_req(0, 1'b0, 3'b010, 32'h1001_0002, 32'h0);
    checks++; if (last_rc !== 5 || last_rd !== 32'hAABE_EF22) begin
      errors++; $display("FAIL lw_split: got cycle %0d data %h expected 5 aabeef22", last_rc, last_rd);
    end
    do_req(0, 1'b1, 3'b010, 32'h1001_0008, 32'h1234_5678);
    checks++; if (last_rc !== 2 || last_ens !== 1) begin
      errors++; $display("FAIL sw_timing: got cycle %0d beats %0d expected 2 1", last_rc, last_ens);
    end
    do_req(0, 1'b0, 3'b010, 32'h1001_0008, 32'h0);
    checks++; if (last_rd !== 32'h1234_5678) begin errors++; $display("FAIL sw_readback: got %h expected 12345678", last_rd); end
  endtask

  task automatic test_faults;
    logic        wr  [5];
    logic [2:0]  fmt [5];
    logic [31:0] adr [5];
    wr[0] = 1'b0; fmt[0] = 3'b010; adr[0] = 32'h1002_0000;
    wr[1] = 1'b1; fmt[1] = 3'b010; adr[1] = 32'h1001_FFFE;
    wr[2] = 1'b0; fmt[2] = 3'b011; adr[2] = 32'h1001_0000;
    wr[3] = 1'b1; fmt[3] = 3'b100; adr[3] = 32'h1001_0000;
    wr[4] = 1'b0; fmt[4] = 3'b010; adr[4] = 32'h1000_FFFC;
    for (int i = 0; i < 5; i++) begin
      do_req(0, wr[i], fmt[i], adr[i], 32'hFFFF_FFFF);
      checks++; if (last_rc !== 1 || last_re !== 1'b1) begin
        errors++; $display("FAIL fault[%0d]: got cycle %0d err %b expected 1 1", i, last_rc, last_re);
      end
      checks++; if (last_ens !== 0 || last_rd !== 32'h0) begin
        errors++; $display("FAIL fault_no_access[%0d]: got beats %0d data %h expected 0 0", i, last_ens, last_rd);
      end
    end
    do_req(0, 1'b0, 3'b010, 32'h1001_FFFC, 32'h0);
    checks++; if (last_rc !== 3 || last_re !== 1'b0 || last_rd !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL last_word: got cycle %0d err %b data %h expected 3 0 cafef00d", last_rc, last_re, last_rd);
    end
  endtask

  task automatic test_no_misaligned;
    do_req(1, 1'b0, 3'b010, 32'h1001_0002, 32'h0);
    checks++; if (last_rc !== 1 || last_re !== 1'b1 || last_ens !== 0) begin
      errors++; $display("FAIL nomis_lw: got cycle %0d err %b beats %0d expected 1 1 0", last_rc, last_re, last_ens);
    end
    do_req(1, 1'b0, 3'b001, 32'h1001_0001, 32'h0);
    checks++; if (last_rc !== 3 || last_re !== 1'b0 || last_rd !== 32'h0000_2233) begin
      errors++; $display("FAIL nomis_lh_inword: got cycle %0d err %b data %h expected 3 0 00002233", last_rc, last_re, last_rd);
    end
  endtask

  task automatic test_latency3;
    int resp_seen;
    do_req(2, 1'b0, 3'b001, 32'h1001_0003, 32'h0);
    checks++; if (last_rc !== 9 || last_rd !== 32'hFFFF_BB81) begin
      errors++; $display("FAIL l3_split_lh: got cycle %0d data %h expected 9 ffffbb81", last_rc, last_rd);
    end
    @(negedge clock);
    while (!rdy[2]) @(negedge clock);
    req_write = 1'b0; req_format = 3'b010; req_address = 32'h1001_0004; req_wdata = 32'h0;
    rv[2] = 1'b1;
    @(posedge clock);
    #1 rv[2] = 1'b0;
    @(negedge clock);
    checks++; if (men[2] !== 1'b1) begin errors++; $display("FAIL l3_lo_beat: got %b expected 1", men[2]); end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if ({rsv[2], rse[2], men[2], mwe[2], mbe[2], madr[2], rsd[2], mwd[2]} !== 87'h0 || rdy[2] !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs: got %h ready %b expected 0 1",
                         {rsv[2], rse[2], men[2], mwe[2], mbe[2], madr[2], rsd[2], mwd[2]}, rdy[2]);
    end
    resp_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (rsv[2]) resp_seen++;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (rsv[2]) resp_seen++;
    end
    checks++; if (resp_seen !== 0) begin errors++; $display("FAIL midreset_no_resp: got %0d expected 0", resp_seen); end
    checks++; if (rdy[2] !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", rdy[2]); end
    do_req(2, 1'b0, 3'b010, 32'h1001_0004, 32'h0);
    checks++; if (last_rc !== 5 || last_rd !== 32'h8899_AABB || last_re !== 1'b0) begin
      errors++; $display("FAIL l3_lw_after_reset: got cycle %0d data %h err %b expected 5 8899aabb 0", last_rc, last_rd, last_re);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rv = 3'b000;
    req_write = 1'b0; req_format = 3'b000; req_address = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_lw();
    test_byte_half_loads();
    test_back_to_back();
    test_stores();
    test_faults();
    test_no_misaligned();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
